// File: rtl/inst_line_fetch_wrapper_if.sv
// inst_line_fetch_wrapper_if: CPU fetch handshake plus AXI AR/R instruction channels.
// master = the fetch bridge, slave = the CPU IF stage and the AXI memory side.
interface inst_line_fetch_wrapper_if #(
    parameter int PC_WIDTH       = 32,
    parameter int AXI_ADDR_WIDTH = 40
);
    logic [PC_WIDTH-1:0]       PC;
    logic                      Inst_Req_Valid;
    logic                      Inst_Req_Ready;
    logic                      Inst_Flush;
    logic [31:0]               Instruction;
    logic                      Inst_Valid;
    logic                      Inst_Ready;
    logic [AXI_ADDR_WIDTH-1:0] cpu_inst_araddr;
    logic                      cpu_inst_arvalid;
    logic                      cpu_inst_arready;
    logic [2:0]                cpu_inst_arsize;
    logic [1:0]                cpu_inst_arburst;
    logic [7:0]                cpu_inst_arlen;
    logic [31:0]               cpu_inst_rdata;
    logic                      cpu_inst_rvalid;
    logic                      cpu_inst_rready;
    logic                      cpu_inst_rlast;

    modport master (
        input  PC, Inst_Req_Valid, Inst_Flush, Inst_Ready,
               cpu_inst_arready, cpu_inst_rdata, cpu_inst_rvalid, cpu_inst_rlast,
        output Inst_Req_Ready, Instruction, Inst_Valid,
               cpu_inst_araddr, cpu_inst_arvalid, cpu_inst_arsize, cpu_inst_arburst,
               cpu_inst_arlen, cpu_inst_rready
    );
    modport slave (
        output PC, Inst_Req_Valid, Inst_Flush, Inst_Ready,
               cpu_inst_arready, cpu_inst_rdata, cpu_inst_rvalid, cpu_inst_rlast,
        input  Inst_Req_Ready, Instruction, Inst_Valid,
               cpu_inst_araddr, cpu_inst_arvalid, cpu_inst_arsize, cpu_inst_arburst,
               cpu_inst_arlen, cpu_inst_rready
    );
endinterface

// File: rtl/inst_line_fetch_wrapper.sv
// inst_line_fetch_wrapper: one-line instruction buffer filled by AXI INCR bursts.
// Optional INST_FETCH_PERF_EN adds hit/miss/stall performance counters.
module inst_line_fetch_wrapper #(
    parameter int PC_WIDTH       = 32,
    parameter int AXI_ADDR_WIDTH = 40,
    parameter int LINE_WORDS     = 4
) (
    input logic cpu_clk,
    input logic cpu_reset,
    inst_line_fetch_wrapper_if.master bus
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int IW  = $clog2(LINE_WORDS);
    localparam int OFF = IW + 2;
    localparam int CW  = IW + 1;

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    state_t                 state, state_nxt;
    logic [31:0]            line_buf [LINE_WORDS];
    logic [PC_WIDTH-OFF-1:0] tag;
    logic [PC_WIDTH-3:0]    req_word;
    logic [CW-1:0]          beat_cnt;
    logic                   line_valid, flush_pend, accept, hit, beat, beat_keep;

    assign accept    = bus.Inst_Req_Valid && bus.Inst_Req_Ready;
    assign hit       = line_valid && !bus.Inst_Flush && tag == bus.PC[PC_WIDTH-1:OFF];
    assign beat      = state == R && bus.cpu_inst_rvalid;
    assign beat_keep = beat && beat_cnt < CW'(LINE_WORDS);

    always_comb begin
        state_nxt            = state;
        bus.Inst_Req_Ready   = state == IDLE && !cpu_reset;
        bus.cpu_inst_arvalid = state == AR;
        bus.cpu_inst_rready  = state == R;
        bus.Inst_Valid       = state == RESP;
        bus.Instruction      = line_buf[req_word[IW-1:0]];
        bus.cpu_inst_araddr  = AXI_ADDR_WIDTH'({req_word[PC_WIDTH-3:IW], {OFF{1'b0}}});
        bus.cpu_inst_arsize  = 3'b010;
        bus.cpu_inst_arburst = 2'b01;
        bus.cpu_inst_arlen   = 8'(LINE_WORDS - 1);
        case (state)
            IDLE:    state_nxt = accept ? (hit ? RESP : AR) : IDLE;
            AR:      state_nxt = bus.cpu_inst_arready ? R : AR;
            R:       state_nxt = beat && bus.cpu_inst_rlast ? RESP : R;
            default: state_nxt = bus.Inst_Ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge cpu_clk)
        state <= cpu_reset ? IDLE : state_nxt;

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            line_valid <= 1'b0;
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (state == AR && bus.cpu_inst_arready)
                beat_cnt <= '0;
            else if (beat_keep)
                beat_cnt <= beat_cnt + 1'b1;
            flush_pend <= state == IDLE ? 1'b0 : flush_pend || (bus.Inst_Flush && (state == AR || state == R));
            // Only a full, unflushed burst whose rlast lands on the final word validates the line.
            if (beat && bus.cpu_inst_rlast)
                line_valid <= beat_cnt == CW'(LINE_WORDS - 1) && !flush_pend && !bus.Inst_Flush;
            else if (bus.Inst_Flush || state == AR)
                line_valid <= 1'b0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (accept)
            req_word <= bus.PC[PC_WIDTH-1:2];
        if (beat && bus.cpu_inst_rlast)
            tag <= req_word[PC_WIDTH-3:IW];
        if (beat_keep)
            line_buf[beat_cnt[IW-1:0]] <= bus.cpu_inst_rdata;
    end

`ifdef INST_FETCH_PERF_EN
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            perf_hit_cnt   <= '0;
            perf_miss_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_hit_cnt   <= perf_hit_cnt + 32'(accept && hit);
            perf_miss_cnt  <= perf_miss_cnt + 32'(accept && !hit);
            perf_stall_cnt <= perf_stall_cnt + 32'(state == AR || state == R);
        end
    end
`endif
endmodule

// File: tb/tb_inst_line_fetch_wrapper.sv
// tb_inst_line_fetch_wrapper: scoreboard bench driving CPU fetches and an AXI memory model.
module tb_inst_line_fetch_wrapper;
    logic cpu_clk = 1'b0;
    logic cpu_reset = 1'b1;
    inst_line_fetch_wrapper_if bus ();
`ifdef INST_FETCH_PERF_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt, perf_stall_cnt;
`endif

    inst_line_fetch_wrapper dut (
        .cpu_clk(cpu_clk),
        .cpu_reset(cpu_reset),
        .bus(bus)
`ifdef INST_FETCH_PERF_EN
        ,
        .perf_hit_cnt(perf_hit_cnt),
        .perf_miss_cnt(perf_miss_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit model_valid = 1'b0;
    logic [31:0] model_line = '0;
    int exp_hit_n = 0;
    int exp_miss_n = 0;
    int exp_stall_n = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge cpu_clk);
        #1;
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a >> 2) + 32'hA0 - 32'h400;
    endfunction

    task automatic flush_pulse;
        bus.Inst_Flush = 1'b1;
        tick;
        bus.Inst_Flush = 1'b0;
        model_valid = 1'b0;
    endtask

    task automatic check_perf(input string tag);
`ifdef INST_FETCH_PERF_EN
        check({tag, "_hit"}, perf_hit_cnt, exp_hit_n);
        check({tag, "_miss"}, perf_miss_cnt, exp_miss_n);
        check({tag, "_stall"}, perf_stall_cnt, exp_stall_n);
`endif
    endtask

    task automatic fetch(input logic [31:0] pc, input int ar_delay, input int nbeats,
                         input int ir_delay, input int flush_beat, input int rst_beat,
                         input bit flush_acc);
        logic [31:0] line;
        bit hit;
        line = {pc[31:4], 4'h0};
        hit = model_valid && model_line == line && !flush_acc;
        bus.PC = pc;
        bus.Inst_Req_Valid = 1'b1;
        bus.Inst_Flush = flush_acc;
        check("req_ready", bus.Inst_Req_Ready, 1);
        if (rst_beat < 0) exp_q.push_back(mem(pc));
        if (hit) exp_hit_n++; else exp_miss_n++;
        tick;
        bus.Inst_Req_Valid = 1'b0;
        bus.Inst_Flush = 1'b0;
        check("req_ready_busy", bus.Inst_Req_Ready, 0);
        if (hit) begin
            check("hit_no_ar", bus.cpu_inst_arvalid, 0);
        end else begin
            check("arlen", bus.cpu_inst_arlen, 3);
            check("arsize", bus.cpu_inst_arsize, 2);
            check("arburst", bus.cpu_inst_arburst, 1);
            for (int i = 0; i <= ar_delay; i++) begin
                check("arvalid", bus.cpu_inst_arvalid, 1);
                check("araddr", bus.cpu_inst_araddr, {8'h0, line});
                exp_stall_n++;
                bus.cpu_inst_arready = (i == ar_delay);
                tick;
            end
            bus.cpu_inst_arready = 1'b0;
            check("ar_done", bus.cpu_inst_arvalid, 0);
            for (int b = 0; b < nbeats; b++) begin
                if (b == rst_beat) begin
                    cpu_reset = 1'b1;
                    bus.cpu_inst_rvalid = 1'b0;
                    bus.cpu_inst_rlast = 1'b0;
                    tick;
                    check("rst_arvalid", bus.cpu_inst_arvalid, 0);
                    check("rst_rready", bus.cpu_inst_rready, 0);
                    check("rst_inst_valid", bus.Inst_Valid, 0);
                    check("rst_req_ready", bus.Inst_Req_Ready, 0);
                    cpu_reset = 1'b0;
                    tick;
                    model_valid = 1'b0;
                    exp_hit_n = 0;
                    exp_miss_n = 0;
                    exp_stall_n = 0;
                    return;
                end
                check("rready", bus.cpu_inst_rready, 1);
                check("early_valid", bus.Inst_Valid, 0);
                bus.cpu_inst_rvalid = 1'b1;
                bus.cpu_inst_rdata = mem(line + 32'(4 * b));
                bus.cpu_inst_rlast = (b == nbeats - 1);
                bus.Inst_Flush = (b == flush_beat);
                exp_stall_n++;
                tick;
            end
            bus.cpu_inst_rvalid = 1'b0;
            bus.cpu_inst_rlast = 1'b0;
            bus.Inst_Flush = 1'b0;
            model_valid = nbeats == 4 && flush_beat < 0;
            model_line = line;
        end
        for (int i = 0; i < ir_delay; i++) begin
            check("hold_valid", bus.Inst_Valid, 1);
            check("hold_inst", bus.Instruction, exp_q[0]);
            tick;
        end
        bus.Inst_Ready = 1'b1;
        check("inst_valid", bus.Inst_Valid, 1);
        if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
        else check("instruction", bus.Instruction, exp_q.pop_front());
        tick;
        bus.Inst_Ready = 1'b0;
        check("inst_done", bus.Inst_Valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        bus.PC = '0;
        bus.Inst_Req_Valid = 1'b0;
        bus.Inst_Flush = 1'b0;
        bus.Inst_Ready = 1'b0;
        bus.cpu_inst_arready = 1'b0;
        bus.cpu_inst_rdata = '0;
        bus.cpu_inst_rvalid = 1'b0;
        bus.cpu_inst_rlast = 1'b0;
        tick;
        tick;
        check("reset_arvalid", bus.cpu_inst_arvalid, 0);
        check("reset_rready", bus.cpu_inst_rready, 0);
        check("reset_inst_valid", bus.Inst_Valid, 0);
        check("reset_req_ready", bus.Inst_Req_Ready, 0);
        cpu_reset = 1'b0;
        tick;
        fetch(32'h1004, 0, 4, 0, -1, -1, 1'b0);
        fetch(32'h1008, 0, 4, 0, -1, -1, 1'b0);
        fetch(32'h100C, 0, 4, 0, -1, -1, 1'b0);
        check_perf("perf_first");
        fetch(32'h1010, 3, 4, 2, -1, -1, 1'b0);
        fetch(32'h2000, 0, 4, 0, 1, -1, 1'b0);
        fetch(32'h2004, 0, 4, 0, -1, -1, 1'b0);
        fetch(32'h2008, 0, 4, 1, -1, -1, 1'b0);
        fetch(32'h3000, 0, 2, 0, -1, -1, 1'b0);
        fetch(32'h3004, 0, 4, 0, -1, -1, 1'b0);
        fetch(32'h3008, 0, 4, 0, -1, -1, 1'b0);
        flush_pulse;
        fetch(32'h300C, 1, 4, 0, -1, -1, 1'b0);
        fetch(32'h3000, 0, 4, 0, -1, -1, 1'b1);
        fetch(32'h3004, 0, 4, 0, -1, -1, 1'b0);
        fetch(32'h4000, 0, 4, 0, -1, 1, 1'b0);
        fetch(32'h3004, 0, 4, 0, -1, -1, 1'b0);
        check_perf("perf_final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_line_fetch_wrapper.md
Name: inst_line_fetch_wrapper

Overview:
- Next-generation instruction-fetch bridge between the custom CPU's PC/Instruction handshake and the AXI instruction port.
- Replaces single-beat pass-through with burst line fills (INCR, LINE_WORDS beats) into a one-line buffer.
- Sequential fetches that hit the buffered line are answered without AXI traffic.
- Sits between the CPU IF stage and the AXI AR/R instruction channels; same CPU-side handshake semantics as the existing fetch path.

Parameters:
- PC_WIDTH, 32: CPU PC width.
- AXI_ADDR_WIDTH, 40: AXI address width; zero-extended from PC.
- LINE_WORDS, 4: 32-bit words per line; power of two, 2..16. OFF = log2(LINE_WORDS)+2.

Ports:
- cpu_clk  in  1  sole clock.
- cpu_reset  in  1  synchronous, active-high reset.
- PC  in  PC_WIDTH  fetch address, word aligned.
- Inst_Req_Valid  in  1  fetch request valid.
- Inst_Req_Ready  out  1  request accepted when both high.
- Inst_Flush  in  1  one-cycle pulse; invalidates the line buffer.
- Instruction  out  32  fetched word.
- Inst_Valid  out  1  Instruction valid.
- Inst_Ready  in  1  CPU accepts Instruction.
- cpu_inst_araddr  out  AXI_ADDR_WIDTH  line-aligned burst address.
- cpu_inst_arvalid  out  1  AR valid.
- cpu_inst_arready  in  1  AR ready.
- cpu_inst_arsize  out  3  constant 3'b010.
- cpu_inst_arburst  out  2  constant 2'b01 (INCR).
- cpu_inst_arlen  out  8  constant LINE_WORDS-1.
- cpu_inst_rdata  in  32  read data.
- cpu_inst_rvalid  in  1  R valid.
- cpu_inst_rready  out  1  R ready.
- cpu_inst_rlast  in  1  last beat.

Behaviour:
- Clock and reset: one clock, cpu_clk. cpu_reset is synchronous and active-high; it overrides every other event, including mid-burst.
- Reset values: state=IDLE, line_valid=0, beat_cnt=0, cpu_inst_arvalid=0, cpu_inst_rready=0, Inst_Valid=0. Inst_Req_Ready=0 while cpu_reset is high.
- Registers:
  - buf[LINE_WORDS] x 32 line storage.
  - tag = PC[PC_WIDTH-1:OFF].
  - line_valid, req_pc, beat_cnt (saturating at LINE_WORDS), flush_pend.
- IDLE:
  - Inst_Req_Ready=1.
  - On accept, latch req_pc.
  - Hit (line_valid and tag match): go to RESP next cycle.
  - Miss: go to AR.
- AR:
  - arvalid=1; araddr={zeros, req_pc[PC_WIDTH-1:OFF], OFF'b0}, held stable until arready.
  - On arvalid&arready: clear beat_cnt, go to R.
- R:
  - rready=1.
  - Each rvalid beat writes buf[beat_cnt] and increments beat_cnt. Beats beyond LINE_WORDS are dropped; the counter saturates.
  - On a beat with rlast: load tag from req_pc. line_valid=1 only if exactly LINE_WORDS beats were received and no flush_pend; otherwise line_valid=0. Go to RESP.
- RESP:
  - Inst_Valid=1; Instruction=buf[req_pc[OFF-1:2]], held stable until Inst_Ready.
  - On Inst_Valid&Inst_Ready: go to IDLE. Back-to-back request acceptance follows on the next cycle.
- Latency:
  - Hit: request accepted in cycle n, Inst_Valid in n+1.
  - Miss: arvalid in n+1; Inst_Valid the cycle after the rlast beat.
- Short burst (rlast before LINE_WORDS beats): the response is still issued. Words not received are unspecified, and the line stays invalid.
- Inst_Flush:
  - In IDLE or RESP: line_valid cleared next cycle; a pending RESP still completes with already-fetched data.
  - In AR or R: sets flush_pend, so the line is not validated at burst end. flush_pend clears on entry to IDLE.
  - Flush coincident with a request accept in IDLE: the lookup is treated as a miss.
- At most one outstanding AXI burst. Inst_Req_Ready=0 in every state except IDLE.

Optional Feature:
- Macro INST_FETCH_PERF_EN.
- Defined: adds outputs perf_hit_cnt (32), perf_miss_cnt (32) and perf_stall_cnt (32).
  - perf_hit_cnt: +1 per accepted hit.
  - perf_miss_cnt: +1 per accepted miss.
  - perf_stall_cnt: +1 every cycle in AR or R.
  - All wrap modulo 2^32 and are cleared by cpu_reset only (not by Inst_Flush).
- Undefined: no such ports or registers exist; all other behaviour is identical.

Test Plan:
- Cold fetch, LINE_WORDS=4: PC=0x1004 after reset -> araddr=0x1000, arlen=3, arsize=2, arburst=1. Slave returns 0xA0,0xA1,0xA2,0xA3 (rlast on 4th beat) -> Instruction=0xA1, Inst_Valid one cycle after rlast.
- Sequential hit: then PC=0x1008, 0x100C -> no arvalid; Instruction=0xA2, then 0xA3, each Inst_Valid one cycle after accept.
- Line miss and stalls: PC=0x1010 with arready delayed 3 cycles and Inst_Ready low 2 cycles -> araddr stable 0x1010 for 4 cycles; Instruction held until accepted.
- Flush mid-burst: pulse Inst_Flush during beat 2 of the 0x2000 fill -> response returned; a following fetch of PC=0x2004 issues a new AR to 0x2000.
- Short burst and reset: rlast on beat 2 -> response given, next same-line fetch misses. Assert cpu_reset mid-R -> next cycle arvalid=0, rready=0, Inst_Valid=0; the next fetch misses.
- With INST_FETCH_PERF_EN: the first two scenarios -> perf_miss_cnt=1, perf_hit_cnt=2, perf_stall_cnt equals the counted AR+R cycles.
